// File: rtl/mips_decode_execute_stage_pkg.sv
// Shared types and constants for the ID/EX pipeline register and its hazard logic.
// Defines the packed control bundle layout and the bubble control word.
package mips_decode_execute_stage_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        PC_INC      = 2'd0,
        PC_BRANCH   = 2'd1,
        PC_JUMP     = 2'd2,
        PC_JUMP_REG = 2'd3
    } pc_action_e;

    typedef enum logic [1:0] {
        WB_ALU    = 2'd0,
        WB_MEMORY = 2'd1,
        WB_PC     = 2'd2,
        WB_IMM    = 2'd3
    } wb_source_e;

    typedef struct packed {
        logic [18:0] reserved;
        logic [3:0]  aluOperation;
        logic        aluSourceImmediate;
        logic        shiftSourceShamt;
        logic        branchNotEqual;
        wb_source_e  registerWriteDataSource;
        pc_action_e  pcAction;
        logic        memoryWriteEnable;
        logic        registerWriteEnable;
    } control_t;

    localparam int unsigned CONTROL_BUNDLE_W = $bits(control_t);

    // A bubble must not write anything and must let the PC advance normally.
    localparam control_t CONTROL_BUBBLE = '{
        reserved:                '0,
        aluOperation:            '0,
        aluSourceImmediate:      1'b0,
        shiftSourceShamt:        1'b0,
        branchNotEqual:          1'b0,
        registerWriteDataSource: WB_ALU,
        pcAction:                PC_INC,
        memoryWriteEnable:       1'b0,
        registerWriteEnable:     1'b0
    };

    function automatic logic src_matches(
        input logic                  used,
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] dst
    );
        return used & (src == dst);
    endfunction

endpackage

// File: rtl/mips_decode_execute_stage_if.sv
// ID-to-EX bus: decoded instruction fields in, latched EX fields and stall out.
// master drives the ID side and downstream controls; slave is the pipeline register.
interface mips_decode_execute_stage_if
    import mips_decode_execute_stage_pkg::*;
#(
    parameter int unsigned CONTROL_W = 32,
    parameter int unsigned DATA_W    = 32
) ();

    logic                  idValid;
    logic [CONTROL_W-1:0]  idControl;
    logic                  idRegWriteEnable;
    logic                  idMemWriteEnable;
    logic                  idIsLoad;
    logic [REG_ADDR_W-1:0] idWriteAddr;
    logic [REG_ADDR_W-1:0] idReadAddr1;
    logic [REG_ADDR_W-1:0] idReadAddr2;
    logic                  idRead1Used;
    logic                  idRead2Used;
    logic [DATA_W-1:0]     idData1;
    logic [DATA_W-1:0]     idData2;
    logic [DATA_W-1:0]     idImmediate;
    logic [DATA_W-1:0]     idPc;
    logic                  exStall;
    logic                  flush;

    logic                  upstreamStall;
    logic                  exValid;
    logic [CONTROL_W-1:0]  exControl;
    logic                  exRegWriteEnable;
    logic                  exMemWriteEnable;
    logic                  exIsLoad;
    logic [REG_ADDR_W-1:0] exWriteAddr;
    logic [DATA_W-1:0]     exData1;
    logic [DATA_W-1:0]     exData2;
    logic [DATA_W-1:0]     exImmediate;
    logic [DATA_W-1:0]     exPc;

    modport master (
        output idValid, idControl, idRegWriteEnable, idMemWriteEnable, idIsLoad,
               idWriteAddr, idReadAddr1, idReadAddr2, idRead1Used, idRead2Used,
               idData1, idData2, idImmediate, idPc, exStall, flush,
        input  upstreamStall, exValid, exControl, exRegWriteEnable, exMemWriteEnable,
               exIsLoad, exWriteAddr, exData1, exData2, exImmediate, exPc
    );

    modport slave (
        input  idValid, idControl, idRegWriteEnable, idMemWriteEnable, idIsLoad,
               idWriteAddr, idReadAddr1, idReadAddr2, idRead1Used, idRead2Used,
               idData1, idData2, idImmediate, idPc, exStall, flush,
        output upstreamStall, exValid, exControl, exRegWriteEnable, exMemWriteEnable,
               exIsLoad, exWriteAddr, exData1, exData2, exImmediate, exPc
    );

endinterface

// File: rtl/mips_decode_execute_stage_load_use_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds the ID instruction.
// Pure combinational so the forwarding unit can share it.
module mips_load_use_detect
    import mips_decode_execute_stage_pkg::*;
(
    input  logic                  i_exValid,
    input  logic                  i_exIsLoad,
    input  logic [REG_ADDR_W-1:0] i_exWriteAddr,
    input  logic                  i_idValid,
    input  logic                  i_idRead1Used,
    input  logic                  i_idRead2Used,
    input  logic [REG_ADDR_W-1:0] i_idReadAddr1,
    input  logic [REG_ADDR_W-1:0] i_idReadAddr2,
    output logic                  o_loadUse
);

    logic w_producer;
    logic w_match1;
    logic w_match2;

    // r0 is hard-wired, so a load targeting it never produces a dependency.
    assign w_producer = i_exValid & i_exIsLoad & (i_exWriteAddr != ZERO_REG);
    assign w_match1   = src_matches(i_idRead1Used, i_idReadAddr1, i_exWriteAddr);
    assign w_match2   = src_matches(i_idRead2Used, i_idReadAddr2, i_exWriteAddr);
    assign o_loadUse  = w_producer & i_idValid & (w_match1 | w_match2);

endmodule

// File: rtl/mips_decode_execute_stage.sv
// ID/EX pipeline register with load-use bubble insertion, downstream hold and flush.
// Optional performance counters enabled by defining MIPS_DECODE_EXECUTE_PERF_EN.
module mips_decode_execute_stage
    import mips_decode_execute_stage_pkg::*;
#(
    parameter int unsigned CONTROL_W = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned PERF_W    = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    mips_decode_execute_stage_if.slave    bus,
    output logic [PERF_W-1:0]             perfBubbles,
    output logic [PERF_W-1:0]             perfFlushes
);

    localparam logic [CONTROL_W-1:0] BUBBLE_CTRL = CONTROL_W'(CONTROL_BUBBLE);

    logic                  r_exValid;
    logic [CONTROL_W-1:0]  r_exControl;
    logic                  r_exRegWriteEnable;
    logic                  r_exMemWriteEnable;
    logic                  r_exIsLoad;
    logic [REG_ADDR_W-1:0] r_exWriteAddr;
    logic [DATA_W-1:0]     r_exData1;
    logic [DATA_W-1:0]     r_exData2;
    logic [DATA_W-1:0]     r_exImmediate;
    logic [DATA_W-1:0]     r_exPc;

    logic w_loadUse;
    logic w_bubble;

    mips_load_use_detect u_load_use_detect (
        .i_exValid     (r_exValid),
        .i_exIsLoad    (r_exIsLoad),
        .i_exWriteAddr (r_exWriteAddr),
        .i_idValid     (bus.idValid),
        .i_idRead1Used (bus.idRead1Used),
        .i_idRead2Used (bus.idRead2Used),
        .i_idReadAddr1 (bus.idReadAddr1),
        .i_idReadAddr2 (bus.idReadAddr2),
        .o_loadUse     (w_loadUse)
    );

    // A flush kills the ID instruction, so the hazard it would have caused is moot.
    assign bus.upstreamStall = bus.exStall | (w_loadUse & ~bus.flush);
    assign w_bubble          = bus.flush | w_loadUse;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_exValid          <= 1'b0;
            r_exControl        <= BUBBLE_CTRL;
            r_exRegWriteEnable <= 1'b0;
            r_exMemWriteEnable <= 1'b0;
            r_exIsLoad         <= 1'b0;
            r_exWriteAddr      <= '0;
            r_exData1          <= '0;
            r_exData2          <= '0;
            r_exImmediate      <= '0;
            r_exPc             <= '0;
        end else if (!bus.exStall) begin
            if (w_bubble) begin
                r_exValid          <= 1'b0;
                r_exControl        <= BUBBLE_CTRL;
                r_exRegWriteEnable <= 1'b0;
                r_exMemWriteEnable <= 1'b0;
                r_exIsLoad         <= 1'b0;
                r_exWriteAddr      <= '0;
                r_exData1          <= '0;
                r_exData2          <= '0;
                r_exImmediate      <= '0;
                r_exPc             <= '0;
            end else begin
                r_exValid          <= bus.idValid;
                r_exControl        <= bus.idControl;
                r_exRegWriteEnable <= bus.idRegWriteEnable & bus.idValid;
                r_exMemWriteEnable <= bus.idMemWriteEnable & bus.idValid;
                r_exIsLoad         <= bus.idIsLoad & bus.idValid;
                r_exWriteAddr      <= bus.idWriteAddr;
                r_exData1          <= bus.idData1;
                r_exData2          <= bus.idData2;
                r_exImmediate      <= bus.idImmediate;
                r_exPc             <= bus.idPc;
            end
        end
    end

    assign bus.exValid          = r_exValid;
    assign bus.exControl        = r_exControl;
    assign bus.exRegWriteEnable = r_exRegWriteEnable & r_exValid;
    assign bus.exMemWriteEnable = r_exMemWriteEnable & r_exValid;
    assign bus.exIsLoad         = r_exIsLoad & r_exValid;
    assign bus.exWriteAddr      = r_exWriteAddr;
    assign bus.exData1          = r_exData1;
    assign bus.exData2          = r_exData2;
    assign bus.exImmediate      = r_exImmediate;
    assign bus.exPc             = r_exPc;

`ifdef MIPS_DECODE_EXECUTE_PERF_EN
    logic [PERF_W-1:0] r_perfBubbles;
    logic [PERF_W-1:0] r_perfFlushes;

    // Counters follow the register's own priority: a held cycle counts nothing.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_perfBubbles <= '0;
            r_perfFlushes <= '0;
        end else if (!bus.exStall) begin
            if (bus.flush) begin
                if (r_perfFlushes != '1) r_perfFlushes <= r_perfFlushes + PERF_W'(1);
            end else if (w_loadUse) begin
                if (r_perfBubbles != '1) r_perfBubbles <= r_perfBubbles + PERF_W'(1);
            end
        end
    end

    assign perfBubbles = r_perfBubbles;
    assign perfFlushes = r_perfFlushes;
`else
    assign perfBubbles = '0;
    assign perfFlushes = '0;
`endif

endmodule

// File: tb/tb_mips_decode_execute_stage.sv
// Scoreboard bench for the ID/EX register: directed vectors push expected EX state,
// a monitor pops and compares one record per cycle.
module tb_mips_decode_execute_stage;
    import mips_decode_execute_stage_pkg::*;

    localparam int unsigned CW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned PW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic [PW-1:0] perfBubbles;
    logic [PW-1:0] perfFlushes;

    mips_decode_execute_stage_if #(.CONTROL_W(CW), .DATA_W(DW)) bus ();

    mips_decode_execute_stage #(
        .CONTROL_W (CW),
        .DATA_W    (DW),
        .PERF_W    (PW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus.slave),
        .perfBubbles (perfBubbles),
        .perfFlushes (perfFlushes)
    );

    always #5 clock = ~clock;

    typedef enum {K_LOAD, K_BUBBLE, K_HOLD, K_RESET} kind_e;

    typedef struct {
        logic          rst;
        logic          v;
        logic [CW-1:0] ctrl;
        logic          rwe, mwe, ld;
        logic [4:0]    wa, ra1, ra2;
        logic          u1, u2;
        logic [DW-1:0] d1, d2, imm, pc;
        logic          stall, flush;
    } vec_t;

    typedef struct {
        logic          upStall;
        logic          valid;
        logic [CW-1:0] ctrl;
        logic          rwe, mwe, ld;
        logic [4:0]    wa;
        logic [DW-1:0] d1, d2, imm, pc;
        logic [PW-1:0] pb, pf;
    } exp_t;

    exp_t        q[$];
    exp_t        prev_ex;
    exp_t        pend;
    exp_t        cur;
    bit          have_pend = 1'b0;
    bit          mon_busy  = 1'b0;
    int unsigned n_checks  = 0;
    int unsigned n_pass    = 0;

    function automatic vec_t ins(input logic [DW-1:0] pc, input logic ld, input logic rwe,
                                 input logic mwe, input logic [4:0] wa, input logic [4:0] ra1,
                                 input logic u1, input logic [4:0] ra2, input logic u2);
        vec_t t;
        t.rst = 1'b1;  t.v = 1'b1;
        t.ctrl = {16'hC0DE, pc[15:0]};
        t.rwe = rwe;   t.mwe = mwe;  t.ld = ld;
        t.wa = wa;     t.ra1 = ra1;  t.ra2 = ra2;
        t.u1 = u1;     t.u2 = u2;
        t.d1 = pc ^ 32'h1111_0000;
        t.d2 = pc ^ 32'h2222_0000;
        t.imm = pc ^ 32'h3333_0000;
        t.pc = pc;
        t.stall = 1'b0; t.flush = 1'b0;
        return t;
    endfunction

    function automatic vec_t idle();
        vec_t t;
        t = '{default: '0};
        t.rst = 1'b1;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        reset                = t.rst;
        bus.idValid          = t.v;
        bus.idControl        = t.ctrl;
        bus.idRegWriteEnable = t.rwe;
        bus.idMemWriteEnable = t.mwe;
        bus.idIsLoad         = t.ld;
        bus.idWriteAddr      = t.wa;
        bus.idReadAddr1      = t.ra1;
        bus.idReadAddr2      = t.ra2;
        bus.idRead1Used      = t.u1;
        bus.idRead2Used      = t.u2;
        bus.idData1          = t.d1;
        bus.idData2          = t.d2;
        bus.idImmediate      = t.imm;
        bus.idPc             = t.pc;
        bus.exStall          = t.stall;
        bus.flush            = t.flush;
    endtask

    // es: upstreamStall expected this cycle; k/pb/pf: EX state after the edge.
    task automatic issue(input vec_t t, input logic es, input kind_e k,
                         input int unsigned pb, input int unsigned pf);
        exp_t e;
        @(negedge clock);
        drive(t);
        case (k)
            K_LOAD: begin
                e.valid = t.v;        e.ctrl = t.ctrl;
                e.rwe = t.rwe & t.v;  e.mwe = t.mwe & t.v;  e.ld = t.ld & t.v;
                e.wa = t.wa;  e.d1 = t.d1;  e.d2 = t.d2;  e.imm = t.imm;  e.pc = t.pc;
            end
            K_HOLD: e = prev_ex;
            default: begin
                e.valid = 1'b0;  e.ctrl = CW'(CONTROL_BUBBLE);
                e.rwe = 1'b0;  e.mwe = 1'b0;  e.ld = 1'b0;
                e.wa = '0;  e.d1 = '0;  e.d2 = '0;  e.imm = '0;  e.pc = '0;
            end
        endcase
        e.upStall = es;
`ifdef MIPS_DECODE_EXECUTE_PERF_EN
        e.pb = PW'(pb);
        e.pf = PW'(pf);
`else
        e.pb = '0;
        e.pf = '0;
`endif
        prev_ex = e;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (have_pend) begin
                chk("exValid",          64'(bus.exValid),          64'(pend.valid));
                chk("exControl",        64'(bus.exControl),        64'(pend.ctrl));
                chk("exRegWriteEnable", 64'(bus.exRegWriteEnable), 64'(pend.rwe));
                chk("exMemWriteEnable", 64'(bus.exMemWriteEnable), 64'(pend.mwe));
                chk("exIsLoad",         64'(bus.exIsLoad),         64'(pend.ld));
                chk("exWriteAddr",      64'(bus.exWriteAddr),      64'(pend.wa));
                chk("exData1",          64'(bus.exData1),          64'(pend.d1));
                chk("exData2",          64'(bus.exData2),          64'(pend.d2));
                chk("exImmediate",      64'(bus.exImmediate),      64'(pend.imm));
                chk("exPc",             64'(bus.exPc),             64'(pend.pc));
                chk("perfBubbles",      64'(perfBubbles),          64'(pend.pb));
                chk("perfFlushes",      64'(perfFlushes),          64'(pend.pf));
                have_pend = 1'b0;
            end
            if (q.size() > 0) begin
                cur = q.pop_front();
                chk("upstreamStall", 64'(bus.upstreamStall), 64'(cur.upStall));
                pend = cur;
                have_pend = 1'b1;
            end
            mon_busy = have_pend || (q.size() > 0);
        end
    end

    initial begin
        vec_t v;
        v = idle();
        v.rst = 1'b0;
        drive(v);
        @(posedge clock);

        // Reset state
        issue(v, 1'b0, K_RESET, 0, 0);

        // lw r2 ; add r3,r2,r4 -> one bubble
        issue(ins(32'h100, 1, 1, 0, 5'd2, 5'd1, 1, 5'd0, 0), 1'b0, K_LOAD, 0, 0);
        v = ins(32'h104, 0, 1, 0, 5'd3, 5'd2, 1, 5'd4, 1);
        issue(v, 1'b1, K_BUBBLE, 1, 0);
        issue(v, 1'b0, K_LOAD, 1, 0);
        issue(idle(), 1'b0, K_LOAD, 1, 0);

        // lw r0 ; add r3,r0,r4 -> no hazard
        issue(ins(32'h200, 1, 1, 0, 5'd0, 5'd1, 1, 5'd0, 0), 1'b0, K_LOAD, 1, 0);
        issue(ins(32'h204, 0, 1, 0, 5'd3, 5'd0, 1, 5'd4, 1), 1'b0, K_LOAD, 1, 0);

        // lw r2 ; sw using r2 as source 2 -> bubble
        issue(ins(32'h300, 1, 1, 0, 5'd2, 5'd29, 1, 5'd0, 0), 1'b0, K_LOAD, 1, 0);
        v = ins(32'h304, 0, 0, 1, 5'd0, 5'd29, 1, 5'd2, 1);
        issue(v, 1'b1, K_BUBBLE, 2, 0);
        issue(v, 1'b0, K_LOAD, 2, 0);

        // lw r2 ; source 2 = r2 but unused -> no bubble
        issue(ins(32'h308, 1, 1, 0, 5'd2, 5'd29, 1, 5'd0, 0), 1'b0, K_LOAD, 2, 0);
        issue(ins(32'h30C, 0, 0, 1, 5'd0, 5'd29, 1, 5'd2, 0), 1'b0, K_LOAD, 2, 0);

        // Back-to-back dependent loads, then a consumer of the second
        issue(ins(32'h310, 1, 1, 0, 5'd5, 5'd6, 1, 5'd0, 0), 1'b0, K_LOAD, 2, 0);
        v = ins(32'h314, 1, 1, 0, 5'd6, 5'd5, 1, 5'd0, 0);
        issue(v, 1'b1, K_BUBBLE, 3, 0);
        issue(v, 1'b0, K_LOAD, 3, 0);
        v = ins(32'h318, 0, 1, 0, 5'd7, 5'd6, 1, 5'd0, 1);
        issue(v, 1'b1, K_BUBBLE, 4, 0);
        issue(v, 1'b0, K_LOAD, 4, 0);

        // Flush coinciding with a load-use hazard
        issue(ins(32'h400, 1, 1, 0, 5'd2, 5'd1, 1, 5'd0, 0), 1'b0, K_LOAD, 4, 0);
        v = ins(32'h404, 0, 1, 0, 5'd3, 5'd2, 1, 5'd4, 1);
        v.flush = 1'b1;
        issue(v, 1'b0, K_BUBBLE, 4, 1);

        // Downstream hold for three cycles with flush pending
        issue(ins(32'h500, 0, 1, 0, 5'd8, 5'd9, 1, 5'd0, 0), 1'b0, K_LOAD, 4, 1);
        v = ins(32'h504, 0, 1, 0, 5'd11, 5'd12, 1, 5'd0, 0);
        v.flush = 1'b1;
        v.stall = 1'b1;
        issue(v, 1'b1, K_HOLD, 4, 1);
        issue(v, 1'b1, K_HOLD, 4, 1);
        issue(v, 1'b1, K_HOLD, 4, 1);
        v.stall = 1'b0;
        issue(v, 1'b0, K_BUBBLE, 4, 2);

        // Reset mid-stream with a valid load in EX
        issue(ins(32'h600, 1, 1, 0, 5'd10, 5'd1, 1, 5'd0, 0), 1'b0, K_LOAD, 4, 2);
        v = ins(32'h604, 0, 1, 0, 5'd11, 5'd10, 1, 5'd0, 0);
        v.rst = 1'b0;
        issue(v, 1'b1, K_RESET, 0, 0);
        v.rst = 1'b1;
        v.stall = 1'b1;
        issue(v, 1'b1, K_HOLD, 0, 0);
        v.stall = 1'b0;
        issue(v, 1'b0, K_LOAD, 0, 0);
        issue(idle(), 1'b0, K_LOAD, 0, 0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            drive(idle());
            #3;
            if (!mon_busy) break;
        end
        if (mon_busy) begin
            n_checks++;
            $display("FAIL drain: scoreboard still holds %0d records, required 0", q.size() + 1);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
